// File: rtl/vic_bus_pkg.sv
// Shared types and constants for the VIC-II bus arbiter: arbitration state
// encoding, steal threshold and the default address/data widths.
package vic_bus_pkg;

  localparam int VIC_ADDR_W = 14;
  localparam int VIC_DATA_W = 12;

  // Number of phi2 slots the CPU may still use for writes after BA drops.
  localparam logic [1:0] BA_WRITE_SLOTS = 2'd3;

  typedef enum logic [1:0] {
    PHI1_VIC,
    PHI2_CPU,
    PHI2_HOST,
    PHI2_STOLEN
  } vic_bus_state_e;

  // CPU or host holds the address bus in these states; the VIC holds it otherwise.
  function automatic logic owns_bus(input vic_bus_state_e s);
    return (s == PHI2_CPU) || (s == PHI2_HOST);
  endfunction

endpackage

// File: rtl/vic_ba_counter.sv
// Detects phi0 edges against last clk's phi0 and counts phi2 slots that
// start with BA low, saturating at BA_WRITE_SLOTS; steal flags a stolen slot.
module vic_ba_counter
  import vic_bus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic phi0,
  input  logic ba,
  output logic slot_start,
  output logic phi_rise,
  output logic steal
);

  logic       r_phi0;
  logic [1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phi0 <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_phi0 <= phi0;
      if (ba)
        r_cnt <= '0;
      else if (phi_rise && (r_cnt != BA_WRITE_SLOTS))
        r_cnt <= r_cnt + 2'd1;
    end
  end

  assign slot_start = rst_n & (phi0 ^ r_phi0);
  assign phi_rise   = slot_start & phi0;
  // A BA fall coinciding with the rise sees r_cnt==0, so that slot is still served and counted.
  assign steal      = phi_rise & ~ba & (r_cnt == BA_WRITE_SLOTS);

endmodule

// File: rtl/vic_bus_arbiter.sv
// Shares one RAM/ROM bus between VIC (phi1, stolen phi2) and CPU/host (phi2).
// Host preload port is active only when VIC_BUS_ARB_HOST_PORT_EN is defined.
module vic_bus_arbiter
  import vic_bus_pkg::*;
#(
  parameter int ADDR_W = VIC_ADDR_W,
  parameter int DATA_W = VIC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phi0,
  input  logic              ba,
  input  logic [ADDR_W-1:0] vic_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic              cpu_ack,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              aec,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_we
);

`ifdef VIC_BUS_ARB_HOST_PORT_EN
  localparam bit HOST_EN = 1'b1;
`else
  localparam bit HOST_EN = 1'b0;
`endif

  logic           w_slot_start;
  logic           w_phi_rise;
  logic           w_steal;
  logic           w_cpu_acc;
  logic           w_host_acc;
  logic           w_aec;
  vic_bus_state_e r_state;
  vic_bus_state_e w_state_nxt;
  logic           r_ba;
  logic           r_cpu_ack;
  logic           r_host_ack;
  logic [ADDR_W-1:0] r_addr;

  vic_ba_counter u_ba_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .phi0       (phi0),
    .ba         (ba),
    .slot_start (w_slot_start),
    .phi_rise   (w_phi_rise),
    .steal      (w_steal)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_acc   = 1'b0;
    w_host_acc  = 1'b0;
    if (!rst_n) begin
      w_state_nxt = PHI1_VIC;
    end else if (w_slot_start) begin
      if (!w_phi_rise) begin
        w_state_nxt = PHI1_VIC;
      end else if (w_steal) begin
        w_state_nxt = PHI2_STOLEN;
      end else if (cpu_req) begin
        w_state_nxt = PHI2_CPU;
        // Reads wait for RDY (BA as seen last clk); writes go through.
        w_cpu_acc   = cpu_we | r_ba;
      end else if (host_req && HOST_EN) begin
        w_state_nxt = PHI2_HOST;
        w_host_acc  = 1'b1;
      end else begin
        w_state_nxt = PHI2_CPU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= PHI1_VIC;
      r_ba       <= 1'b1;
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ba       <= ba;
      r_cpu_ack  <= w_cpu_acc;
      r_host_ack <= w_host_acc;
      if (w_cpu_acc)
        r_addr <= cpu_addr;
      else if (w_host_acc)
        r_addr <= host_addr;
    end
  end

  // Bus ownership follows the next state so the slot-start clk already drives the new owner.
  assign w_aec = owns_bus(w_state_nxt);
  assign aec   = w_aec;
  assign ram_we = (w_cpu_acc & cpu_we) | w_host_acc;

  always_comb begin
    ram_addr = vic_addr;
    ram_di   = '0;
    if (w_cpu_acc) begin
      ram_addr = cpu_addr;
      ram_di   = cpu_wdata;
    end else if (w_host_acc) begin
      ram_addr = host_addr;
      ram_di   = host_wdata;
    end else if (w_aec) begin
      ram_addr = r_addr;
    end
  end

  // Outputs are also forced in the reset clk itself, which aborts any access in flight.
  assign cpu_ack  = rst_n & r_cpu_ack;
  assign host_ack = rst_n & r_host_ack;
  assign cpu_rdy  = ~rst_n | r_ba;

endmodule
